// File: rtl/program_loader_if.sv
// Handshake bundle between the program loader and its environment:
// the CPU front-panel controls, the program ROM and the user byte source.
interface program_loader_if;
   logic       i_start;
   logic       i_waiting;
   logic       i_take_input;
   logic [7:0] i_rom_data;
   logic       i_user_valid;
   logic [7:0] i_user_data;
   logic [7:0] o_rom_addr;
   logic [7:0] o_data_out;
   logic       o_load_addr;
   logic       o_load_data;
   logic       o_execute;
   logic       o_input_taken;
   logic       o_user_ready;
   logic       o_busy;
   logic       o_done;

   modport master (
      input  i_start, i_waiting, i_take_input, i_rom_data, i_user_valid, i_user_data,
      output o_rom_addr, o_data_out, o_load_addr, o_load_data, o_execute,
             o_input_taken, o_user_ready, o_busy, o_done
   );

   modport slave (
      output i_start, i_waiting, i_take_input, i_rom_data, i_user_valid, i_user_data,
      input  o_rom_addr, o_data_out, o_load_addr, o_load_data, o_execute,
             o_input_taken, o_user_ready, o_busy, o_done
   );
endinterface

// File: rtl/program_loader.sv
// Operator stand-in: copies a program from ROM into CPU RAM over the front-panel
// handshake, starts it, feeds WRIM input requests and reports when the CPU halts.
module program_loader #(
   parameter int         PROG_LEN  = 16,
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter int         HOLD      = 2
) (
   input logic            i_clk,
   input logic            i_reset,
   program_loader_if.master bus
);

   localparam int               CNT_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
   localparam logic [7:0]       LAST_INDEX = 8'(PROG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE, ROM_RD, ADDR_WAIT, ADDR_PULSE, DATA_WAIT, DATA_PULSE,
      EXEC_WAIT, EXEC_PULSE, RUN, IN_PULSE, DONE
   } state_t;

   state_t           state;
   logic [7:0]       index;
   logic [7:0]       data_reg;
   logic [7:0]       rom_addr;
   logic [7:0]       data_out;
   logic [CNT_W-1:0] hold_cnt;
   logic             armed;
   logic             load_addr;
   logic             load_data;
   logic             execute;
   logic             input_taken;
   logic             user_ready;

   logic addr_entry;
   logic data_entry;
   logic input_req;

   // CPU front-panel phases decoded from its waiting/take_input pair.
   assign addr_entry = bus.i_waiting && !bus.i_take_input;
   assign data_entry = !bus.i_waiting && bus.i_take_input;
   assign input_req  = bus.i_waiting && bus.i_take_input;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         index       <= 8'h00;
         data_reg    <= 8'h00;
         rom_addr    <= 8'h00;
         data_out    <= 8'h00;
         hold_cnt    <= '0;
         armed       <= 1'b0;
         load_addr   <= 1'b0;
         load_data   <= 1'b0;
         execute     <= 1'b0;
         input_taken <= 1'b0;
         user_ready  <= 1'b0;
      end else begin
         user_ready <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  index    <= 8'h00;
                  rom_addr <= 8'h00;
                  state    <= ROM_RD;
               end
            end
            ROM_RD: begin
               data_out <= BASE_ADDR + index;
               state    <= ADDR_WAIT;
            end
            // ROM address is stable here, so the read data can be latched every cycle.
            ADDR_WAIT: begin
               data_reg <= bus.i_rom_data;
               if (addr_entry) begin
                  load_addr <= 1'b1;
                  hold_cnt  <= HOLD_LAST;
                  state     <= ADDR_PULSE;
               end
            end
            ADDR_PULSE: begin
               if (hold_cnt == '0) begin
                  load_addr <= 1'b0;
                  data_out  <= data_reg;
                  state     <= DATA_WAIT;
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            DATA_WAIT: begin
               if (data_entry) begin
                  load_data <= 1'b1;
                  hold_cnt  <= HOLD_LAST;
                  state     <= DATA_PULSE;
               end
            end
            DATA_PULSE: begin
               if (hold_cnt == '0) begin
                  load_data <= 1'b0;
                  if (index == LAST_INDEX) begin
                     data_out <= 8'h00;
                     state    <= EXEC_WAIT;
                  end else begin
                     index    <= index + 8'd1;
                     rom_addr <= index + 8'd1;
                     state    <= ROM_RD;
                  end
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            EXEC_WAIT: begin
               if (addr_entry) begin
                  execute  <= 1'b1;
                  hold_cnt <= HOLD_LAST;
                  state    <= EXEC_PULSE;
               end
            end
            EXEC_PULSE: begin
               if (hold_cnt == '0) begin
                  execute <= 1'b0;
                  armed   <= 1'b0;
                  state   <= RUN;
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            // Arming waits for the CPU to leave its previous waiting phase,
            // so a stale request or the pre-run address state is never misread.
            RUN: begin
               if (!armed) begin
                  if (!bus.i_waiting) begin
                     armed <= 1'b1;
                  end
               end else if (input_req) begin
                  if (bus.i_user_valid) begin
                     data_out    <= bus.i_user_data;
                     input_taken <= 1'b1;
                     hold_cnt    <= HOLD_LAST;
                     state       <= IN_PULSE;
                  end
               end else if (addr_entry) begin
                  state <= DONE;
               end
            end
            IN_PULSE: begin
               if (hold_cnt == '0) begin
                  input_taken <= 1'b0;
                  user_ready  <= 1'b1;
                  armed       <= 1'b0;
                  state       <= RUN;
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_rom_addr    = rom_addr;
   assign bus.o_data_out    = data_out;
   assign bus.o_load_addr   = load_addr;
   assign bus.o_load_data   = load_data;
   assign bus.o_execute     = execute;
   assign bus.o_input_taken = input_taken;
   assign bus.o_user_ready  = user_ready;
   assign bus.o_busy        = (state != IDLE) && (state != DONE);
   assign bus.o_done        = (state == DONE);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a small behavioural CPU front panel with RAM,
// a synchronous ROM, and a scoreboard of expected load addresses/data.
module tb_program_loader;

   localparam int PLEN = 3;
   localparam int HOLD = 2;

   typedef enum logic [1:0] {C_ADDR, C_DATA, C_RUN, C_IN} cpu_state_t;

   typedef struct {
      logic       is_addr;
      logic [7:0] val;
   } sb_entry_t;

   typedef struct {
      logic [23:0] prog;
      logic        use_user;
      logic [7:0]  user_byte;
      int          user_delay;
      logic [7:0]  chk_addr;
      logic [7:0]  chk_val;
      int          exp_inputs;
   } vector_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sel = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   program_loader_if bus_a ();
   program_loader_if bus_w ();

   program_loader #(.PROG_LEN(PLEN), .BASE_ADDR(8'h00), .HOLD(HOLD)) dut_a (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_a)
   );

   program_loader #(.PROG_LEN(PLEN), .BASE_ADDR(8'hFE), .HOLD(HOLD)) dut_w (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_w)
   );

   logic [7:0] rom [256];

   always @(posedge clk) begin
      bus_a.i_rom_data <= rom[bus_a.o_rom_addr];
      bus_w.i_rom_data <= rom[bus_w.o_rom_addr];
   end

   logic       la, ld, ex, it, ur;
   logic [7:0] dout;
   assign la   = sel ? bus_w.o_load_addr   : bus_a.o_load_addr;
   assign ld   = sel ? bus_w.o_load_data   : bus_a.o_load_data;
   assign ex   = sel ? bus_w.o_execute     : bus_a.o_execute;
   assign it   = sel ? bus_w.o_input_taken : bus_a.o_input_taken;
   assign ur   = sel ? bus_w.o_user_ready  : bus_a.o_user_ready;
   assign dout = sel ? bus_w.o_data_out    : bus_a.o_data_out;

   // CPU front panel: address entry, RAM write, run (NOOP=01, WRIM=02 addr, HALT=00), input request.
   cpu_state_t cpu_state = C_ADDR;
   logic [7:0] ram [256];
   logic [7:0] c_addr = 8'h00, c_data = 8'h00, pc = 8'h00, target = 8'h00;
   logic       tick = 1'b0;
   logic       p_la = 1'b0, p_ld = 1'b0, p_ex = 1'b0, p_it = 1'b0;
   logic       cpu_waiting, cpu_take;

   assign cpu_waiting        = (cpu_state == C_ADDR) || (cpu_state == C_IN);
   assign cpu_take           = (cpu_state == C_DATA) || (cpu_state == C_IN);
   assign bus_a.i_waiting    = cpu_waiting;
   assign bus_a.i_take_input = cpu_take;
   assign bus_w.i_waiting    = cpu_waiting;
   assign bus_w.i_take_input = cpu_take;

   always @(posedge clk) begin
      p_la <= la;
      p_ld <= ld;
      p_ex <= ex;
      p_it <= it;
      if (reset) begin
         cpu_state <= C_ADDR;
         pc        <= 8'h00;
         tick      <= 1'b0;
         for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
      end else begin
         case (cpu_state)
            C_ADDR: begin
               if (la) c_addr <= dout;
               if (p_la && !la) cpu_state <= C_DATA;
               else if (p_ex && !ex) begin
                  cpu_state <= C_RUN;
                  pc        <= 8'h00;
                  tick      <= 1'b0;
               end
            end
            C_DATA: begin
               if (ld) c_data <= dout;
               if (p_ld && !ld) begin
                  ram[c_addr] <= c_data;
                  cpu_state   <= C_ADDR;
               end
            end
            C_RUN: begin
               tick <= !tick;
               if (tick) begin
                  case (ram[pc])
                     8'h01: pc <= pc + 8'd1;
                     8'h02: begin
                        target    <= ram[pc + 8'd1];
                        pc        <= pc + 8'd2;
                        cpu_state <= C_IN;
                     end
                     default: cpu_state <= C_ADDR;
                  endcase
               end
            end
            C_IN: begin
               if (it) c_data <= dout;
               if (p_it && !it) begin
                  ram[target] <= c_data;
                  cpu_state   <= C_RUN;
                  tick        <= 1'b0;
               end
            end
            default: cpu_state <= C_ADDR;
         endcase
      end
   end

   sb_entry_t sbq [$];
   logic m_la = 1'b0, m_ld = 1'b0, m_ex = 1'b0, m_it = 1'b0;
   int   w_la = 0, w_ld = 0, w_ex = 0, w_it = 0;
   int   cnt_la = 0, cnt_ld = 0, cnt_ex = 0, cnt_it = 0, cnt_ur = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_expect(input string name, input logic kind);
      sb_entry_t e;
      if (sbq.size() == 0) begin
         checkOutput({name, "_underflow"}, 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         checkOutput({name, "_kind"}, 32'(e.is_addr), 32'(kind));
         checkOutput(name, 32'(dout), 32'(e.val));
      end
   endtask

   task automatic push_load(input logic [7:0] base);
      for (int i = 0; i < PLEN; i++) begin
         sbq.push_back('{1'b1, base + 8'(i)});
         sbq.push_back('{1'b0, rom[i]});
      end
   endtask

   task automatic clear_counts();
      cnt_la = 0; cnt_ld = 0; cnt_ex = 0; cnt_it = 0; cnt_ur = 0;
   endtask

   task automatic monitor_step();
      if (reset) begin
         w_la = 0; w_ld = 0; w_ex = 0; w_it = 0;
         m_la = la; m_ld = ld; m_ex = ex; m_it = it;
         return;
      end
      if (la && !m_la) begin cnt_la++; pop_expect("load_addr_value", 1'b1); end
      if (ld && !m_ld) begin cnt_ld++; pop_expect("load_data_value", 1'b0); end
      if (ex && !m_ex) cnt_ex++;
      if (it && !m_it) cnt_it++;
      if (ur) begin
         cnt_ur++;
         checkOutput("user_ready_align", 32'({it, m_it}), 32'(2'b01));
      end
      if (la) w_la++; else if (m_la) begin checkOutput("load_addr_width", 32'(w_la), 32'(HOLD)); w_la = 0; end
      if (ld) w_ld++; else if (m_ld) begin checkOutput("load_data_width", 32'(w_ld), 32'(HOLD)); w_ld = 0; end
      if (ex) w_ex++; else if (m_ex) begin checkOutput("execute_width", 32'(w_ex), 32'(HOLD)); w_ex = 0; end
      if (it) w_it++; else if (m_it) begin checkOutput("input_taken_width", 32'(w_it), 32'(HOLD)); w_it = 0; end
      m_la = la; m_ld = ld; m_ex = ex; m_it = it;
   endtask

   task automatic applyStimulus(input logic which);
      if (which) bus_w.i_start = 1'b1;
      else bus_a.i_start = 1'b1;
      @(negedge clk);
      bus_a.i_start = 1'b0;
      bus_w.i_start = 1'b0;
   endtask

   task automatic load_rom(input logic [23:0] p);
      rom[0] = p[23:16];
      rom[1] = p[15:8];
      rom[2] = p[7:0];
   endtask

   task automatic wait_done(input string name, input logic use_user, input logic [7:0] ubyte, input int delay);
      int   n;
      int   dly;
      logic presented;
      logic pending;
      n = 0; dly = 0; presented = 1'b0; pending = use_user;
      while (!(sel ? bus_w.o_done : bus_a.o_done) && n < 3000) begin
         @(negedge clk);
         n++;
         if (pending) begin
            if (bus_a.o_user_ready) begin
               bus_a.i_user_valid = 1'b0;
               pending = 1'b0;
            end else if (!presented && cpu_state == C_IN) begin
               if (dly == delay) begin
                  bus_a.i_user_data  = ubyte;
                  bus_a.i_user_valid = 1'b1;
                  presented = 1'b1;
               end else begin
                  dly++;
               end
            end
         end
      end
      checkOutput({name, "_done"}, 32'(sel ? bus_w.o_done : bus_a.o_done), 32'd1);
   endtask

   task automatic wait_rise(input string name, input logic want_data, input int target_cnt);
      int   n;
      int   seen;
      logic p;
      logic s;
      n = 0; seen = 0; p = 1'b0;
      while (seen < target_cnt && n < 500) begin
         @(negedge clk);
         n++;
         s = want_data ? ld : la;
         if (s && !p) seen++;
         p = s;
      end
      checkOutput({name, "_reached"}, 32'(seen), 32'(target_cnt));
   endtask

   task automatic check_run(input string name, input logic [23:0] p, input int inputs);
      checkOutput({name, "_busy"}, 32'(sel ? bus_w.o_busy : bus_a.o_busy), 32'd0);
      checkOutput({name, "_load_addr_cnt"}, 32'(cnt_la), 32'(PLEN));
      checkOutput({name, "_load_data_cnt"}, 32'(cnt_ld), 32'(PLEN));
      checkOutput({name, "_execute_cnt"}, 32'(cnt_ex), 32'd1);
      checkOutput({name, "_input_cnt"}, 32'(cnt_it), 32'(inputs));
      checkOutput({name, "_ready_cnt"}, 32'(cnt_ur), 32'(inputs));
      checkOutput({name, "_sb_left"}, 32'(sbq.size()), 32'd0);
      if (!sel) begin
         checkOutput({name, "_ram0"}, 32'(ram[0]), 32'(p[23:16]));
         checkOutput({name, "_ram1"}, 32'(ram[1]), 32'(p[15:8]));
         checkOutput({name, "_ram2"}, 32'(ram[2]), 32'(p[7:0]));
      end
   endtask

   vector_t vectors [4];

   initial begin
      vectors[0] = '{prog: 24'h010100, use_user: 1'b0, user_byte: 8'h00, user_delay: 0,
                     chk_addr: 8'h01, chk_val: 8'h01, exp_inputs: 0};
      vectors[1] = '{prog: 24'h022000, use_user: 1'b1, user_byte: 8'hA5, user_delay: 10,
                     chk_addr: 8'h20, chk_val: 8'hA5, exp_inputs: 1};
      vectors[2] = '{prog: 24'h023000, use_user: 1'b1, user_byte: 8'h3C, user_delay: 0,
                     chk_addr: 8'h30, chk_val: 8'h3C, exp_inputs: 1};
      vectors[3] = '{prog: 24'h010240, use_user: 1'b1, user_byte: 8'h7E, user_delay: 3,
                     chk_addr: 8'h40, chk_val: 8'h7E, exp_inputs: 1};

      for (int k = 0; k < 256; k++) rom[k] = 8'h00;
      bus_a.i_start = 1'b1; bus_a.i_user_valid = 1'b0; bus_a.i_user_data = 8'h00;
      bus_w.i_start = 1'b0; bus_w.i_user_valid = 1'b0; bus_w.i_user_data = 8'h00;
      reset = 1'b1;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      // Reset held with start high, then idle without a new start.
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'({bus_a.o_rom_addr, bus_a.o_data_out, bus_a.o_load_addr,
                  bus_a.o_load_data, bus_a.o_execute, bus_a.o_input_taken, bus_a.o_user_ready,
                  bus_a.o_busy, bus_a.o_done}), 32'd0);
      reset = 1'b0;
      bus_a.i_start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("idle_quiet_%0d", c), 32'({bus_a.o_load_addr, bus_a.o_load_data,
                     bus_a.o_execute, bus_a.o_input_taken, bus_a.o_user_ready, bus_a.o_busy,
                     bus_a.o_done}), 32'd0);
      end

      for (int v = 0; v < 4; v++) begin
         load_rom(vectors[v].prog);
         clear_counts();
         push_load(8'h00);
         applyStimulus(1'b0);
         wait_done($sformatf("vec%0d", v), vectors[v].use_user, vectors[v].user_byte,
                   vectors[v].user_delay);
         check_run($sformatf("vec%0d", v), vectors[v].prog, vectors[v].exp_inputs);
         checkOutput($sformatf("vec%0d_ram_chk", v), 32'(ram[vectors[v].chk_addr]),
                     32'(vectors[v].chk_val));
      end

      // Start pulse mid-load is ignored; a start from DONE repeats the load.
      load_rom(24'h010100);
      clear_counts();
      push_load(8'h00);
      applyStimulus(1'b0);
      wait_rise("start_ignore", 1'b0, 2);
      applyStimulus(1'b0);
      wait_done("start_ignore", 1'b0, 8'h00, 0);
      check_run("start_ignore", 24'h010100, 0);
      clear_counts();
      push_load(8'h00);
      applyStimulus(1'b0);
      wait_done("restart_done", 1'b0, 8'h00, 0);
      check_run("restart_done", 24'h010100, 0);

      // Reset while load_data is high on byte 1, then a clean reload.
      load_rom(24'h020100);
      clear_counts();
      push_load(8'h00);
      applyStimulus(1'b0);
      wait_rise("midload", 1'b1, 2);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midload_reset", 32'({bus_a.o_rom_addr, bus_a.o_data_out, bus_a.o_load_addr,
                  bus_a.o_load_data, bus_a.o_execute, bus_a.o_input_taken, bus_a.o_user_ready,
                  bus_a.o_busy, bus_a.o_done}), 32'd0);
      sbq.delete();
      clear_counts();
      @(negedge clk);
      reset = 1'b0;
      load_rom(24'h010100);
      push_load(8'h00);
      applyStimulus(1'b0);
      wait_done("reload", 1'b0, 8'h00, 0);
      check_run("reload", 24'h010100, 0);

      // Relocated load wraps FE, FF, 00; program byte at 00 is HALT.
      sel = 1'b1;
      load_rom(24'h010100);
      clear_counts();
      push_load(8'hFE);
      applyStimulus(1'b1);
      wait_done("wrap", 1'b0, 8'h00, 0);
      check_run("wrap", 24'h010100, 0);
      checkOutput("wrap_ram_fe", 32'(ram[8'hFE]), 32'h01);
      checkOutput("wrap_ram_ff", 32'(ram[8'hFF]), 32'h01);
      checkOutput("wrap_ram_00", 32'(ram[8'h00]), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
